morse_decoder_fsm: RTL and testbench
====================================

# morse_decoder_fsm

Receive-side counterpart of the Morse transmitter FSM. It times a single Morse key input against a unit-time strobe and classifies each press as a dot or a dash. At the end of each character it emits a 4-bit character code and a 3-bit length, in exactly the format the transmitter consumes: symbol i is in bit i, 1 = dash, 0 = dot. It sits between the debounced key/button pin and the character buffer. LEDs give live feedback on the symbol being keyed.

## Interface
- DOT_MAX_UNITS, default 2: a press lasting 1..DOT_MAX_UNITS ticks is a dot; longer is a dash. Legal range 1..6.
- CHAR_GAP_UNITS, default 3: key-up time, in ticks, that ends a character. Legal range 1..7.
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- tick_i  input  1  unit-time strobe, one clk_i cycle wide
- key_i  input  1  Morse key level, 1 = pressed; asynchronous to clk_i
- MorseCharacter_o  output  4  last decoded code; bit i = symbol i; bits at or above the length are 0
- MorseLength_o  output  3  symbol count of the last decoded character, 1..4
- valid_o  output  1  one-cycle pulse when a new character is on the outputs
- error_o  output  1  one-cycle pulse when a character with more than 4 symbols is discarded
- dotLed_o  output  1  key held, current press still classifies as a dot
- dashLed_o  output  1  key held, current press already classifies as a dash
- busyLed_o  output  1  a character is in progress (state is not IDLE)

## Operation
- key_i passes through a 2-flop synchronizer to give keySync. All decisions use keySync.
- markCnt is 3 bits, saturating at 7. gapCnt is 3 bits. shiftCode is 4 bits. symCnt is 3 bits. ovf is a 1-bit flag.
- IDLE:
  - Counters and ovf are cleared.
  - keySync=1 -> MARK.
- MARK:
  - Each tick_i increments markCnt.
  - keySync=0 with markCnt=0 is a glitch: it is ignored. Go to SPACE if symCnt>0, else IDLE. gapCnt clears.
  - keySync=0 with markCnt>0 completes a symbol: dash = (markCnt > DOT_MAX_UNITS).
  - If symCnt<4: write the symbol into shiftCode[symCnt] and increment symCnt.
  - Else: set ovf and leave the code unchanged.
  - markCnt clears, gapCnt clears, go to SPACE.
- SPACE:
  - Each tick_i increments gapCnt.
  - keySync=1 -> MARK with markCnt and gapCnt cleared. This has priority over gap completion in the same cycle.
  - When gapCnt reaches CHAR_GAP_UNITS -> EMIT.
- EMIT, one cycle:
  - If ovf=0: load MorseCharacter_o=shiftCode and MorseLength_o=symCnt, and pulse valid_o.
  - If ovf=1: pulse error_o; the outputs keep their previous values.
  - Clear shiftCode, symCnt and ovf, go to IDLE.
  - A key press during EMIT is picked up in IDLE on the next cycle.
- LEDs:
  - dotLed_o = MARK && markCnt ≤ DOT_MAX_UNITS.
  - dashLed_o = MARK && markCnt > DOT_MAX_UNITS.
  - busyLed_o = state≠IDLE.
- MorseCharacter_o and MorseLength_o are registered and hold until the next valid EMIT.

## Timing
- Reset values: state IDLE; every output 0, including MorseCharacter_o=0000 and MorseLength_o=000; all counters, synchronizer flops and ovf are 0.
- Reset asserted mid-character discards the partial character, with no valid_o or error_o.
- Synchronizer latency: 2 cycles from a key_i edge to the keySync edge.
- A tick_i in the same cycle as the keySync edge that leaves MARK or SPACE is not counted; the counters load 0 on that cycle.
- valid_o and error_o assert the cycle after the tick that brings gapCnt to CHAR_GAP_UNITS.
- The character outputs update in the same cycle valid_o asserts.
- markCnt saturates at 7, so very long presses remain dashes.
- At most one of valid_o and error_o is high in any cycle.

## Test plan
- "E": key high for 1 tick, then low for 3 ticks -> valid_o pulse with MorseCharacter_o=0000, MorseLength_o=1.
- "A": 1-tick press, 1-tick gap, 3-tick press, 3-tick gap -> valid_o with 0010, length 2; dashLed_o rises on the 3rd tick of the second press.
- "O": three 4-tick presses with 1-tick gaps -> 0111, length 3. Then "H" (four dots) -> 0000, length 4; the previous outputs hold until that valid_o.
- Overflow: five dots then a 3-tick gap -> error_o for one cycle, no valid_o, outputs unchanged from the previous character.
- Glitch: key high for 3 clk_i cycles with no tick_i -> no symbol recorded, state returns to IDLE, busyLed_o drops, no valid_o.
- rst_i pulsed after two symbols -> all outputs 0 immediately; a following "E" decodes as 0000, length 1.

Source files
------------

// File: rtl/morse_decoder_fsm.sv
// ============================================================================
// Module   : morse_decoder_fsm
// Brief    : Times a Morse key against a unit tick, classifies dots/dashes and
//            emits a 4-bit code plus 3-bit length per character.
// Revision : 1.0
// ============================================================================
`default_nettype none

module morse_decoder_fsm #(
    parameter int DOT_MAX_UNITS  = 2,
    parameter int CHAR_GAP_UNITS = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       key_i,
    output logic [3:0] MorseCharacter_o,
    output logic [2:0] MorseLength_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       dotLed_o,
    output logic       dashLed_o,
    output logic       busyLed_o
);

    localparam logic [2:0] C_DOT_MAX  = 3'(DOT_MAX_UNITS);
    localparam logic [2:0] C_CHAR_GAP = 3'(CHAR_GAP_UNITS);
    localparam logic [2:0] C_CNT_MAX  = 3'd7;
    localparam logic [2:0] C_MAX_SYMS = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t     r_state,    w_state_nxt;
    logic       r_key_meta, r_key_sync;
    logic [2:0] r_mark_cnt, w_mark_cnt_nxt;
    logic [2:0] r_gap_cnt,  w_gap_cnt_nxt;
    logic [3:0] r_shift,    w_shift_nxt;
    logic [2:0] r_sym_cnt,  w_sym_cnt_nxt;
    logic       r_ovf,      w_ovf_nxt;
    logic [3:0] r_char,     w_char_nxt;
    logic [2:0] r_len,      w_len_nxt;
    logic [2:0] w_gap_inc;

    assign w_gap_inc = r_gap_cnt + 3'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_key_meta <= 1'b0;
            r_key_sync <= 1'b0;
        end else begin
            r_key_meta <= key_i;
            r_key_sync <= r_key_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_mark_cnt <= 3'd0;
            r_gap_cnt  <= 3'd0;
            r_shift    <= 4'd0;
            r_sym_cnt  <= 3'd0;
            r_ovf      <= 1'b0;
            r_char     <= 4'd0;
            r_len      <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_mark_cnt <= w_mark_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sym_cnt  <= w_sym_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
            r_char     <= w_char_nxt;
            r_len      <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mark_cnt_nxt = r_mark_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_shift_nxt    = r_shift;
        w_sym_cnt_nxt  = r_sym_cnt;
        w_ovf_nxt      = r_ovf;
        w_char_nxt     = r_char;
        w_len_nxt      = r_len;

        case (r_state)
            S_IDLE: begin
                w_mark_cnt_nxt = 3'd0;
                w_gap_cnt_nxt  = 3'd0;
                w_shift_nxt    = 4'd0;
                w_sym_cnt_nxt  = 3'd0;
                w_ovf_nxt      = 1'b0;
                if (r_key_sync) begin
                    w_state_nxt = S_MARK;
                end
            end
            S_MARK: begin
                if (!r_key_sync) begin
                    w_mark_cnt_nxt = 3'd0;
                    w_gap_cnt_nxt  = 3'd0;
                    if (r_mark_cnt == 3'd0) begin
                        // A press that never saw a tick is dropped as a glitch
                        w_state_nxt = (r_sym_cnt != 3'd0) ? S_SPACE : S_IDLE;
                    end else begin
                        if (r_sym_cnt < C_MAX_SYMS) begin
                            w_shift_nxt[r_sym_cnt[1:0]] = (r_mark_cnt > C_DOT_MAX);
                            w_sym_cnt_nxt               = r_sym_cnt + 3'd1;
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                        w_state_nxt = S_SPACE;
                    end
                end else if (tick_i && (r_mark_cnt != C_CNT_MAX)) begin
                    w_mark_cnt_nxt = r_mark_cnt + 3'd1;
                end
            end
            S_SPACE: begin
                if (r_key_sync) begin
                    w_mark_cnt_nxt = 3'd0;
                    w_gap_cnt_nxt  = 3'd0;
                    w_state_nxt    = S_MARK;
                end else if (tick_i) begin
                    w_gap_cnt_nxt = w_gap_inc;
                    if (w_gap_inc == C_CHAR_GAP) begin
                        // Load on entry to EMIT so the code appears with valid_o
                        w_state_nxt = S_EMIT;
                        if (!r_ovf) begin
                            w_char_nxt = r_shift;
                            w_len_nxt  = r_sym_cnt;
                        end
                    end
                end
            end
            default: begin
                w_shift_nxt   = 4'd0;
                w_sym_cnt_nxt = 3'd0;
                w_ovf_nxt     = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    assign MorseCharacter_o = r_char;
    assign MorseLength_o    = r_len;
    assign valid_o          = (r_state == S_EMIT) && !r_ovf;
    assign error_o          = (r_state == S_EMIT) &&  r_ovf;
    assign dotLed_o         = (r_state == S_MARK) && (r_mark_cnt <= C_DOT_MAX);
    assign dashLed_o        = (r_state == S_MARK) && (r_mark_cnt >  C_DOT_MAX);
    assign busyLed_o        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_morse_decoder_fsm.sv
// ============================================================================
// Module   : tb_morse_decoder_fsm
// Brief    : Randomized self-checking bench; characters are described as press
//            and gap lengths in ticks and decoded from those directly.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_morse_decoder_fsm;

    localparam int DOT_MAX  = 2;
    localparam int CHAR_GAP = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       key_i;
    logic [3:0] MorseCharacter_o;
    logic [2:0] MorseLength_o;
    logic       valid_o;
    logic       error_o;
    logic       dotLed_o;
    logic       dashLed_o;
    logic       busyLed_o;

    morse_decoder_fsm #(
        .DOT_MAX_UNITS  (DOT_MAX),
        .CHAR_GAP_UNITS (CHAR_GAP)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .tick_i           (tick_i),
        .key_i            (key_i),
        .MorseCharacter_o (MorseCharacter_o),
        .MorseLength_o    (MorseLength_o),
        .valid_o          (valid_o),
        .error_o          (error_o),
        .dotLed_o         (dotLed_o),
        .dashLed_o        (dashLed_o),
        .busyLed_o        (busyLed_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total      = 0;
    int n_bad        = 0;
    int n_valid_seen = 0;
    int n_err_seen   = 0;
    int n_valid_exp  = 0;
    int n_err_exp    = 0;
    logic [3:0] last_char = 4'd0;
    logic [2:0] last_len  = 3'd0;
    int d_dur[8];
    int d_gap[8];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Count every output pulse so spurious ones are caught at the end
    always @(negedge clk_i) begin
        if (rst_i === 1'b0) begin
            if (valid_o === 1'b1) n_valid_seen++;
            if (error_o === 1'b1) n_err_seen++;
            if (valid_o === 1'b1 || error_o === 1'b1)
                chk_val("valid_error_exclusive", 32'(valid_o & error_o), 32'd0);
        end
    end

    task automatic step(input logic t, input logic k);
        tick_i = t;
        key_i  = k;
        @(posedge clk_i);
        #1;
    endtask

    task automatic led_chk(input int ticks);
        chk_val("dotLed",  32'(dotLed_o),  32'(ticks <= DOT_MAX));
        chk_val("dashLed", 32'(dashLed_o), 32'(ticks >  DOT_MAX));
        chk_val("busyLed_mark", 32'(busyLed_o), 32'd1);
    endtask

    task automatic emit_chk(input int nsym, input logic [3:0] code);
        if (nsym > 4) begin
            n_err_exp++;
            chk_val("error_pulse", 32'(error_o), 32'd1);
            chk_val("valid_on_ovf", 32'(valid_o), 32'd0);
            chk_val("char_hold", 32'(MorseCharacter_o), 32'(last_char));
            chk_val("len_hold",  32'(MorseLength_o),    32'(last_len));
        end else begin
            n_valid_exp++;
            chk_val("valid_pulse", 32'(valid_o), 32'd1);
            chk_val("error_on_ok", 32'(error_o), 32'd0);
            chk_val("char", 32'(MorseCharacter_o), 32'(code));
            chk_val("len",  32'(MorseLength_o),    32'(nsym));
            last_char = code;
            last_len  = 3'(nsym);
        end
    endtask

    // One unit = 4 clocks with the tick on the first; key edges align to ticks
    task automatic send_char(input int nsym, input int fgap, input bit do_end);
        logic [3:0] code;
        int         g;
        bit         at_emit;
        code = 4'd0;
        for (int i = 0; i < nsym && i < 4; i++)
            if (d_dur[i] > DOT_MAX) code[i] = 1'b1;
        for (int i = 0; i < nsym; i++) begin
            for (int u = 0; u < d_dur[i]; u++) begin
                step(1'b1, 1'b1);
                if (u > 0) led_chk((u > 7) ? 7 : u);
                repeat (3) step(1'b0, 1'b1);
            end
            g = (do_end && i == nsym - 1) ? fgap : d_gap[i];
            for (int u = 0; u < g; u++) begin
                at_emit = do_end && (i == nsym - 1) && (u == CHAR_GAP);
                step(1'b1, 1'b0);
                if (u == 0) led_chk((d_dur[i] > 7) ? 7 : d_dur[i]);
                if (at_emit) emit_chk(nsym, code);
                step(1'b0, 1'b0);
                if (at_emit) begin
                    chk_val("busy_after_emit", 32'(busyLed_o), 32'd0);
                    chk_val("valid_one_cycle", 32'(valid_o | error_o), 32'd0);
                end
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int nsym;
        bit busy_seen;
        rst_i  = 1'b1;
        tick_i = 1'b0;
        key_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_val("rst_char",  32'(MorseCharacter_o), 32'd0);
        chk_val("rst_len",   32'(MorseLength_o),    32'd0);
        chk_val("rst_valid", 32'(valid_o),   32'd0);
        chk_val("rst_error", 32'(error_o),   32'd0);
        chk_val("rst_leds",  32'({dotLed_o, dashLed_o, busyLed_o}), 32'd0);
        rst_i = 1'b0;
        repeat (4) step(1'b0, 1'b0);

        // E
        d_dur[0] = 1;
        send_char(1, CHAR_GAP + 1, 1'b1);
        // A
        d_dur[0] = 1; d_gap[0] = 1; d_dur[1] = 3;
        send_char(2, CHAR_GAP + 1, 1'b1);
        // O
        d_dur[0] = 4; d_gap[0] = 1; d_dur[1] = 4; d_gap[1] = 1; d_dur[2] = 4;
        send_char(3, CHAR_GAP + 1, 1'b1);
        // H
        for (int i = 0; i < 4; i++) begin d_dur[i] = 1; d_gap[i] = 1; end
        send_char(4, CHAR_GAP + 1, 1'b1);
        // five dots: overflow
        for (int i = 0; i < 5; i++) begin d_dur[i] = 1; d_gap[i] = 1; end
        send_char(5, CHAR_GAP + 1, 1'b1);

        // Glitch: short press with no tick
        busy_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1);
            busy_seen = busy_seen | busyLed_o;
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b0);
            busy_seen = busy_seen | busyLed_o;
        end
        chk_val("glitch_busy_seen", 32'(busy_seen), 32'd1);
        chk_val("glitch_busy_drop", 32'(busyLed_o), 32'd0);
        chk_val("glitch_char_hold", 32'(MorseCharacter_o), 32'(last_char));

        // Reset mid-character
        d_dur[0] = 1; d_gap[0] = 1; d_dur[1] = 3; d_gap[1] = 1;
        send_char(2, 0, 1'b0);
        rst_i = 1'b1;
        #1;
        chk_val("midrst_char",  32'(MorseCharacter_o), 32'd0);
        chk_val("midrst_len",   32'(MorseLength_o),    32'd0);
        chk_val("midrst_pulse", 32'({valid_o, error_o}), 32'd0);
        chk_val("midrst_leds",  32'({dotLed_o, dashLed_o, busyLed_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        last_char = 4'd0;
        last_len  = 3'd0;
        repeat (2) step(1'b0, 1'b0);
        d_dur[0] = 1;
        send_char(1, CHAR_GAP + 1, 1'b1);

        // Randomized characters, including overflow and saturating dashes
        for (int n = 0; n < 40; n++) begin
            nsym = int'($urandom_range(1, 6));
            for (int i = 0; i < nsym; i++) begin
                d_dur[i] = int'($urandom_range(1, 9));
                d_gap[i] = int'($urandom_range(1, CHAR_GAP - 1));
            end
            send_char(nsym, CHAR_GAP + 1 + int'($urandom_range(0, 2)), 1'b1);
        end

        repeat (4) step(1'b0, 1'b0);
        chk_val("valid_count", 32'(n_valid_seen), 32'(n_valid_exp));
        chk_val("error_count", 32'(n_err_seen),   32'(n_err_exp));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
